countdown_bcd_core: RTL

- Upstream timing stage of the countdown display path. Holds a 4-digit BCD count and steps it once per prescaled tick.
- Its digit bus, update strobe and done flag feed the SPI display block directly.
- The display block only serialises digits. All load, validity, run/pause and terminal-count decisions are made here.

---
 rtl/countdown_pkg.sv | 56 +++++
 rtl/bcd_digit_cell.sv | 42 ++++
 rtl/countdown_bcd_core.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown BCD core.
// Contents: mode/state enums, BCD digit type, digit-max constants, and helpers for
// mode decoding, terminal values and load validation.
package countdown_pkg;

  typedef enum logic [1:0] {
    MODE_MMSS_DN = 2'd0,
    MODE_DEC_DN  = 2'd1,
    MODE_MMSS_UP = 2'd2,
    MODE_DEC_UP  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADED = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX_DEC  = 4'd9;
  localparam bcd_t DIGIT_MAX_TENS = 4'd5;

  function automatic logic is_mmss(input mode_e m);
    return (m == MODE_MMSS_DN) || (m == MODE_MMSS_UP);
  endfunction

  // Up modes have the MSB of the mode code set.
  function automatic logic is_up(input mode_e m);
    return m[1];
  endfunction

  function automatic logic [15:0] terminal_value(input mode_e m);
    logic [15:0] t;
    case (m)
      MODE_MMSS_UP: t = 16'h5959;
      MODE_DEC_UP:  t = 16'h9999;
      default:      t = 16'h0000;
    endcase
    return t;
  endfunction

  // Every digit must be BCD; tens-of-minutes and tens-of-seconds are limited in MM:SS.
  function automatic logic load_valid(input mode_e m, input logic [15:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (d[i*4 +: 4] > DIGIT_MAX_DEC) ok = 1'b0;
    end
    if (is_mmss(m) && ((d[15:12] > DIGIT_MAX_TENS) || (d[7:4] > DIGIT_MAX_TENS))) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the count chain (combinational next-value).
// Ports:
//   i_digit  current digit value
//   i_max    largest value this digit may hold
//   i_up     1 = count up, 0 = count down
//   i_step   step request from the less significant digit (or the prescaler)
//   o_digit  next digit value
//   o_carry  carry (up) or borrow (down) into the next more significant digit
module bcd_digit_cell
  import countdown_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic [3:0] i_max,
  input  logic       i_up,
  input  logic       i_step,
  output logic [3:0] o_digit,
  output logic       o_carry
);

  always_comb begin
    o_digit = i_digit;
    o_carry = 1'b0;
    if (i_step) begin
      if (i_up) begin
        if (i_digit >= i_max) begin
          o_digit = '0;
          o_carry = 1'b1;
        end else begin
          o_digit = i_digit + 4'd1;
        end
      end else begin
        if (i_digit == '0) begin
          o_digit = i_max;
          o_carry = 1'b1;
        end else begin
          o_digit = i_digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/countdown_bcd_core.sv
// 4-digit BCD countdown/up-count core with prescaled step, load validation and
// run/pause/done control. All outputs are registered.
// Ports:
//   clk        system clock (rising edge)
//   rst        synchronous active-low reset
//   set        load request; samples in_digits and mode
//   in_digits  BCD load value {d3,d2,d1,d0}
//   mode       0 MM:SS down, 1 decimal down, 2 MM:SS up, 3 decimal up
//   start      run enable level (1 run, 0 pause)
//   digits     current count
//   upd        one-cycle strobe when digits changes
//   done       high while in DONE
//   err        one-cycle strobe on a rejected load
//   state      FSM state code
module countdown_bcd_core
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned PW       = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic [15:0] in_digits,
  input  logic [1:0]  mode,
  input  logic        start,
  output logic [15:0] digits,
  output logic        upd,
  output logic        done,
  output logic        err,
  output logic [2:0]  state
);

  localparam logic [PW-1:0] TickLast = PW'(TICK_DIV - 1);

  state_e        r_state;
  mode_e         r_mode;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_digits;
  logic          r_upd;
  logic          r_done;
  logic          r_err;

  logic          w_load_ok;
  logic          w_wrap;
  logic          w_step;
  logic [4:0]    w_chain;
  logic [15:0]   w_next;
  logic [15:0]   w_term;
  logic          w_next_term;

  assign w_load_ok   = load_valid(mode_e'(mode), in_digits);
  assign w_wrap      = (r_presc == TickLast);
  assign w_step      = (r_state == ST_RUN) && start && !set && w_wrap;
  assign w_term      = terminal_value(r_mode);
  // Chain overflow is unreachable from a valid load; treat it as terminal anyway.
  assign w_next_term = (w_next == w_term) || w_chain[4];
  assign w_chain[0]  = w_step;

  for (genvar g = 0; g < 4; g++) begin : g_cell
    logic [3:0] w_max;
    // Odd digits are tens-of-seconds/minutes in MM:SS.
    assign w_max = (is_mmss(r_mode) && (g % 2 == 1)) ? DIGIT_MAX_TENS : DIGIT_MAX_DEC;

    bcd_digit_cell u_cell (
      .i_digit (r_digits[g*4 +: 4]),
      .i_max   (w_max),
      .i_up    (is_up(r_mode)),
      .i_step  (w_chain[g]),
      .o_digit (w_next[g*4 +: 4]),
      .o_carry (w_chain[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_mode   <= MODE_MMSS_DN;
      r_presc  <= '0;
      r_digits <= '0;
      r_upd    <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      r_err <= 1'b0;
      if (set) begin
        // A load (good or bad) freezes counting for this cycle; a coincident wrap is dropped.
        if (w_load_ok) begin
          r_digits <= in_digits;
          r_mode   <= mode_e'(mode);
          r_presc  <= '0;
          r_state  <= ST_LOADED;
          r_upd    <= 1'b1;
          r_done   <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end else begin
        unique case (r_state)
          ST_IDLE: ;
          ST_LOADED: begin
            if (start) begin
              if (r_digits == w_term) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (!start) begin
              r_state <= ST_PAUSE;
            end else if (w_wrap) begin
              r_presc  <= '0;
              r_digits <= w_next;
              r_upd    <= 1'b1;
              if (w_next_term) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
          ST_PAUSE: begin
            if (start) r_state <= ST_RUN;
          end
          ST_DONE: ;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign digits = r_digits;
  assign upd    = r_upd;
  assign done   = r_done;
  assign err    = r_err;
  assign state  = r_state;

endmodule
